// File: rtl/hazard_ctrl_if.sv
// Hazard-control bus between the pipeline (master) and hazard_ctrl (slave).
// Carries the ID/EX/MEM hazard fields plus the stall, flush and counter outputs.
interface hazard_ctrl_if;
    logic [4:0]  Rs_D;
    logic [4:0]  Rt_D;
    logic [4:0]  Rt_E;
    logic        Mem_Read_E;
    logic        Reg_Write_E;
    logic [4:0]  write_reg_E;
    logic        Mem_To_Reg_M;
    logic [4:0]  write_reg_M;
    logic        branch_D;
    logic        jump_D;
    logic        branch_taken_D;
    logic        md_start_E;
    logic        md_done;
    logic        stall_F;
    logic        stall_D;
    logic        clr_D;
    logic        clr_E;
    logic        md_busy;
    logic        md_abort;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    modport master (
        output Rs_D, Rt_D, Rt_E, Mem_Read_E, Reg_Write_E, write_reg_E, Mem_To_Reg_M,
               write_reg_M, branch_D, jump_D, branch_taken_D, md_start_E, md_done,
        input  stall_F, stall_D, clr_D, clr_E, md_busy, md_abort, stall_cnt, flush_cnt
    );

    modport slave (
        input  Rs_D, Rt_D, Rt_E, Mem_Read_E, Reg_Write_E, write_reg_E, Mem_To_Reg_M,
               write_reg_M, branch_D, jump_D, branch_taken_D, md_start_E, md_done,
        output stall_F, stall_D, clr_D, clr_E, md_busy, md_abort, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / branch stalls, taken-branch flush, mul/div wait FSM.
// Define HAZ_PERF_CNT_EN to build the saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);

    typedef enum logic [0:0] {StRun, StMdWait} state_e;

    localparam logic [7:0] WcntLast = 8'(MD_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       md_abort_q, md_abort_d;

    logic lu, bh, flush;
    logic stall, clr_d, busy;

    // Register 0 is hardwired, so it can never carry a dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    always_comb begin
        lu = hz.Mem_Read_E & (reg_match(hz.Rt_E, hz.Rs_D) | reg_match(hz.Rt_E, hz.Rt_D));
        bh = hz.branch_D &
             ((hz.Reg_Write_E &
               (reg_match(hz.write_reg_E, hz.Rs_D) | reg_match(hz.write_reg_E, hz.Rt_D))) |
              (hz.Mem_To_Reg_M &
               (reg_match(hz.write_reg_M, hz.Rs_D) | reg_match(hz.write_reg_M, hz.Rt_D))));
        flush = hz.jump_D | (hz.branch_D & hz.branch_taken_D);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            wcnt_q     <= 8'd0;
            md_abort_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            md_abort_q <= md_abort_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        md_abort_d = 1'b0;
        unique case (state_q)
            StRun: begin
                if (hz.md_start_E) begin
                    state_d = StMdWait;
                    wcnt_d  = 8'd0;
                end
            end
            StMdWait: begin
                // md_done has priority over a coincident timeout.
                if (hz.md_done) begin
                    state_d = StRun;
                end else if (wcnt_q == WcntLast) begin
                    state_d    = StRun;
                    md_abort_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        clr_d = 1'b0;
        busy  = 1'b0;
        if (rst_n) begin
            if (state_q == StMdWait) begin
                stall = 1'b1;
                busy  = 1'b1;
            end else if (lu || bh) begin
                stall = 1'b1;
            end else if (flush) begin
                clr_d = 1'b1;
            end
        end
    end

    assign hz.stall_F  = stall;
    assign hz.stall_D  = stall;
    assign hz.clr_E    = stall;
    assign hz.clr_D    = clr_d;
    assign hz.md_busy  = busy;
    assign hz.md_abort = md_abort_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
        if (clr_d && flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`else
    assign hz.stall_cnt = 32'd0;
    assign hz.flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: default-timeout instance (a) and MD_TIMEOUT=4 instance (b)
// share the same stimulus; control outputs are packed as {stall_F,stall_D,clr_E,clr_D,md_busy}.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] rs_d, rt_d, rt_e, wr_e, wr_m;
    logic       mrd_e, rw_e, m2r_m, br_d, jmp_d, tkn_d, mds_e, mdd;

    hazard_ctrl_if ha ();
    hazard_ctrl_if hb ();

    assign ha.Rs_D = rs_d;          assign hb.Rs_D = rs_d;
    assign ha.Rt_D = rt_d;          assign hb.Rt_D = rt_d;
    assign ha.Rt_E = rt_e;          assign hb.Rt_E = rt_e;
    assign ha.Mem_Read_E = mrd_e;   assign hb.Mem_Read_E = mrd_e;
    assign ha.Reg_Write_E = rw_e;   assign hb.Reg_Write_E = rw_e;
    assign ha.write_reg_E = wr_e;   assign hb.write_reg_E = wr_e;
    assign ha.Mem_To_Reg_M = m2r_m; assign hb.Mem_To_Reg_M = m2r_m;
    assign ha.write_reg_M = wr_m;   assign hb.write_reg_M = wr_m;
    assign ha.branch_D = br_d;      assign hb.branch_D = br_d;
    assign ha.jump_D = jmp_d;       assign hb.jump_D = jmp_d;
    assign ha.branch_taken_D = tkn_d; assign hb.branch_taken_D = tkn_d;
    assign ha.md_start_E = mds_e;   assign hb.md_start_E = mds_e;
    assign ha.md_done = mdd;        assign hb.md_done = mdd;

    hazard_ctrl dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (ha)
    );

    hazard_ctrl #(
        .MD_TIMEOUT (4)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hb)
    );

    logic [4:0] ctl_a, ctl_b;
    assign ctl_a = {ha.stall_F, ha.stall_D, ha.clr_E, ha.clr_D, ha.md_busy};
    assign ctl_b = {hb.stall_F, hb.stall_D, hb.clr_E, hb.clr_D, hb.md_busy};

    int n_cmp = 0;
    int n_fail = 0;

    task automatic clr_inputs();
        rs_d = 5'd0; rt_d = 5'd0; rt_e = 5'd0; wr_e = 5'd0; wr_m = 5'd0;
        mrd_e = 1'b0; rw_e = 1'b0; m2r_m = 1'b0; br_d = 1'b0; jmp_d = 1'b0;
        tkn_d = 1'b0; mds_e = 1'b0; mdd = 1'b0;
    endtask

    // Advance to the next negedge with all inputs idle; caller then sets fields and waits #1.
    task automatic nxt();
        @(negedge clk);
        clr_inputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clr_inputs();
        rst_n = 1'b0;
        mrd_e = 1'b1; rt_e = 5'd5; rs_d = 5'd5;
        #1;
        n_cmp++;
        if (ctl_a !== 5'b00000) begin
            n_fail++; $display("FAIL reset_ctl: got %b want 00000", ctl_a);
        end
        n_cmp++;
        if (ha.md_abort !== 1'b0 || ha.stall_cnt !== 32'd0 || ha.flush_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_regs: abort=%b scnt=%0d fcnt=%0d want 0 0 0",
                     ha.md_abort, ha.stall_cnt, ha.flush_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clr_inputs();
    endtask

    task automatic test_load_use();
        nxt(); mrd_e = 1'b1; rt_e = 5'd5; rs_d = 5'd5; #1;
        n_cmp++;
        if (ctl_a !== 5'b11100) begin n_fail++; $display("FAIL lu_stall: got %b want 11100", ctl_a); end
        nxt(); #1;
        n_cmp++;
        if (ctl_a !== 5'b00000) begin n_fail++; $display("FAIL lu_release: got %b want 00000", ctl_a); end
        nxt(); mrd_e = 1'b1; rt_e = 5'd9; rt_d = 5'd9; rs_d = 5'd2; #1;
        n_cmp++;
        if (ctl_a !== 5'b11100) begin n_fail++; $display("FAIL lu_rt: got %b want 11100", ctl_a); end
        nxt(); mrd_e = 1'b1; rt_e = 5'd0; rs_d = 5'd0; rt_d = 5'd0; #1;
        n_cmp++;
        if (ctl_a !== 5'b00000) begin n_fail++; $display("FAIL lu_reg0: got %b want 00000", ctl_a); end
    endtask

    task automatic test_branch();
        nxt(); br_d = 1'b1; rw_e = 1'b1; wr_e = 5'd7; rt_d = 5'd7; rs_d = 5'd3; #1;
        n_cmp++;
        if (ctl_a !== 5'b11100) begin n_fail++; $display("FAIL bh_ex: got %b want 11100", ctl_a); end
        nxt(); br_d = 1'b1; tkn_d = 1'b1; rt_d = 5'd7; rs_d = 5'd3; #1;
        n_cmp++;
        if (ctl_a !== 5'b00010) begin n_fail++; $display("FAIL br_flush: got %b want 00010", ctl_a); end
        nxt(); #1;
        n_cmp++;
        if (ctl_a !== 5'b00000) begin n_fail++; $display("FAIL br_idle: got %b want 00000", ctl_a); end
        nxt(); br_d = 1'b1; m2r_m = 1'b1; wr_m = 5'd3; rs_d = 5'd3; tkn_d = 1'b1; #1;
        n_cmp++;
        if (ctl_a !== 5'b11100) begin n_fail++; $display("FAIL bh_mem: got %b want 11100", ctl_a); end
        nxt(); br_d = 1'b1; rw_e = 1'b1; wr_e = 5'd0; rs_d = 5'd0; #1;
        n_cmp++;
        if (ctl_a !== 5'b00000) begin n_fail++; $display("FAIL bh_reg0: got %b want 00000", ctl_a); end
        nxt(); mrd_e = 1'b1; rt_e = 5'd4; rs_d = 5'd4; jmp_d = 1'b1; #1;
        n_cmp++;
        if (ctl_a !== 5'b11100) begin n_fail++; $display("FAIL lu_over_jump: got %b want 11100", ctl_a); end
    endtask

    task automatic test_md_done();
        nxt(); mds_e = 1'b1; #1;
        n_cmp++;
        if (ctl_a !== 5'b00000) begin n_fail++; $display("FAIL md_start: got %b want 00000", ctl_a); end
        for (int i = 1; i <= 5; i++) begin
            nxt();
            if (i == 2) begin jmp_d = 1'b1; mrd_e = 1'b1; rt_e = 5'd6; rs_d = 5'd6; end
            if (i == 5) mdd = 1'b1;
            #1;
            n_cmp++;
            if (ctl_a !== 5'b11101 || ha.md_abort !== 1'b0) begin
                n_fail++;
                $display("FAIL md_wait%0d: got %b abort=%b want 11101 abort=0",
                         i, ctl_a, ha.md_abort);
            end
        end
        nxt(); #1;
        n_cmp++;
        if (ctl_a !== 5'b00000 || ha.md_abort !== 1'b0) begin
            n_fail++;
            $display("FAIL md_after_done: got %b abort=%b want 00000 abort=0", ctl_a, ha.md_abort);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        nxt(); mds_e = 1'b1; #1;
        for (int i = 1; i <= 4; i++) begin
            nxt(); #1;
            n_cmp++;
            if (ctl_b !== 5'b11101 || hb.md_abort !== 1'b0) begin
                n_fail++;
                $display("FAIL to_wait%0d: got %b abort=%b want 11101 abort=0",
                         i, ctl_b, hb.md_abort);
            end
        end
        nxt(); #1;
        n_cmp++;
        if (ctl_b !== 5'b00000 || hb.md_abort !== 1'b1) begin
            n_fail++;
            $display("FAIL to_abort: got %b abort=%b want 00000 abort=1", ctl_b, hb.md_abort);
        end
        nxt(); #1;
        n_cmp++;
        if (hb.md_abort !== 1'b0) begin
            n_fail++; $display("FAIL to_pulse_end: got abort=%b want 0", hb.md_abort);
        end
        nxt(); mds_e = 1'b1; #1;
        nxt(); #1;
        nxt(); #1;
        n_cmp++;
        if (ctl_b !== 5'b11101) begin n_fail++; $display("FAIL to_rewait: got %b want 11101", ctl_b); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ctl_b !== 5'b00000 || ctl_a !== 5'b00000 || hb.md_abort !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_wait: got b=%b a=%b abort=%b want 00000 00000 0",
                     ctl_b, ctl_a, hb.md_abort);
        end
        @(negedge clk);
        rst_n = 1'b1;
        nxt(); #1;
        n_cmp++;
        if (ctl_b !== 5'b00000) begin n_fail++; $display("FAIL rst_to_run: got %b want 00000", ctl_b); end
    endtask

    task automatic test_perf_cnt();
        logic [31:0] exp_s, exp_f;
`ifdef HAZ_PERF_CNT_EN
        exp_s = 32'd3; exp_f = 32'd2;
`else
        exp_s = 32'd0; exp_f = 32'd0;
`endif
        do_reset();
        for (int i = 0; i < 3; i++) begin
            nxt(); mrd_e = 1'b1; rt_e = 5'd5; rs_d = 5'd5; #1;
            nxt(); #1;
        end
        for (int i = 0; i < 2; i++) begin
            nxt(); jmp_d = 1'b1; #1;
        end
        nxt(); #1;
        n_cmp++;
        if (ha.stall_cnt !== exp_s || ha.flush_cnt !== exp_f) begin
            n_fail++;
            $display("FAIL perf_cnt: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     ha.stall_cnt, ha.flush_cnt, exp_s, exp_f);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_md_done();
        test_timeout();
        test_perf_cnt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MD_TIMEOUT, default 64, SHALL set the maximum MD_WAIT cycles before the multi-cycle op is aborted (legal range 2..255).
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 Rs_D, Rt_D  in  5 each  source register fields of the instruction in ID.
REQ-005 Rt_E  in  5  Rt field in EX; Mem_Read_E  in  1  EX instruction is a load.
REQ-006 Reg_Write_E  in  1  EX writes a register; write_reg_E  in  5  its destination.
REQ-007 Mem_To_Reg_M  in  1  MEM instruction is a load; write_reg_M  in  5  its destination.
REQ-008 branch_D, jump_D, branch_taken_D  in  1 each  branch/jump in ID, and branch resolved taken.
REQ-009 md_start_E  in  1  multi-cycle mul/div enters EX; md_done  in  1  mul/div unit result ready.
REQ-010 stall_F, stall_D  out  1 each  hold PC and IF/ID registers.
REQ-011 clr_D  out  1  flush IF/ID; clr_E  out  1  drives the ID/EX register clr (bubble insert).
REQ-012 md_busy  out  1  FSM is in MD_WAIT; md_abort  out  1  single-cycle timeout pulse.
REQ-013 stall_cnt, flush_cnt  out  32 each  performance counters (see Configuration).

Function
REQ-014 FSM SHALL have two states, RUN and MD_WAIT, plus an 8-bit wait counter wcnt.
REQ-015 Register 0 SHALL never match in any hazard compare.
REQ-016 Load-use (lu): Mem_Read_E & (Rt_E==Rs_D | Rt_E==Rt_D).
REQ-017 Branch hazard (bh): branch_D & ((Reg_Write_E & write_reg_E matches Rs_D/Rt_D) | (Mem_To_Reg_M & write_reg_M matches Rs_D/Rt_D)).
REQ-018 In RUN, lu|bh SHALL assert stall_F=stall_D=clr_E=1 combinationally in the same cycle, with clr_D=0.
REQ-019 In RUN with no lu/bh, (jump_D | branch_D&branch_taken_D) SHALL assert clr_D=1 for that cycle only.
REQ-020 In RUN, md_start_E SHALL transition to MD_WAIT on the next edge and load wcnt=0; no stall in the start cycle.
REQ-021 In MD_WAIT: stall_F=stall_D=clr_E=1, clr_D=0, md_busy=1; lu/bh/branch inputs are ignored; wcnt increments each cycle.
REQ-022 In MD_WAIT, md_done SHALL return the FSM to RUN on the next edge; stalls drop in the cycle after md_done.
REQ-023 In MD_WAIT with wcnt==MD_TIMEOUT-1 and md_done=0, md_abort SHALL pulse for one cycle and the FSM SHALL return to RUN.
REQ-024 If md_done and the timeout coincide, md_done wins: no md_abort.
REQ-025 Priority: MD_WAIT > lu > bh > taken-branch flush.
REQ-026 Outputs other than md_abort and counters SHALL be combinational from state and inputs (zero latency); md_abort SHALL be registered.

Reset
REQ-027 rst_n low SHALL immediately force RUN, wcnt=0, md_abort=0, and counters=0, including mid-MD_WAIT.
REQ-028 While rst_n is low, all stall/clr/md_busy outputs SHALL be 0.

Configuration
REQ-029 With HAZ_PERF_CNT_EN defined: stall_cnt SHALL increment on each cycle with stall_D=1 and flush_cnt on each cycle with clr_D=1; both saturate at 32'hFFFFFFFF.
REQ-030 Without HAZ_PERF_CNT_EN, stall_cnt and flush_cnt SHALL be constant 0, and no counter flops are synthesized.

Verification
REQ-031 Load r5 in EX (Mem_Read_E=1, Rt_E=5), Rs_D=5 -> stall_F=stall_D=clr_E=1 for exactly 1 cycle; clr_D=0.
REQ-032 Rt_E=0, Mem_Read_E=1, Rs_D=0 -> no stall.
REQ-033 branch_D=1, Reg_Write_E=1, write_reg_E=Rt_D=7 -> stall 1 cycle; next cycle branch_taken_D=1 -> clr_D=1 for 1 cycle.
REQ-034 md_start_E pulse, md_done 5 cycles later -> md_busy/stalls high 5 cycles, low in the cycle after md_done, no md_abort.
REQ-035 MD_TIMEOUT=4, md_done never -> md_abort pulses once on the 4th MD_WAIT cycle, FSM back in RUN; then rst_n pulse mid-MD_WAIT -> all outputs 0 immediately.
REQ-036 HAZ_PERF_CNT_EN defined: 3 load-use stalls plus 2 jumps -> stall_cnt=3, flush_cnt=2; undefined -> both remain 0.
